// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// The tag travels beside each access so that its read return reaches the right requester.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RR,
    ST_DRAIN,
    ST_LOCKED
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Cycles from grant to rvalid.
  localparam int RD_LAT = 3;

  typedef struct packed {
    logic vld;
    logic id;
    logic is_read;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-requester round-robin picker. Grant is combinational from req/mask and the pointer.
// A masked requester is never granted. The pointer moves only when a grant is issued.
module mem_arbiter_rr
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic       ptr;
  logic [1:0] eff;

  // ptr names the requester that wins the next tie.
  always_comb begin
    eff = req & ~mask;
    gnt = 2'b00;
    if (eff[REQ_DBG] && (ptr == REQ_DBG || !eff[REQ_CPU])) begin
      gnt[REQ_DBG] = 1'b1;
    end else if (eff[REQ_CPU]) begin
      gnt[REQ_CPU] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_DBG;
    end else if (gnt[REQ_DBG]) begin
      ptr <= REQ_CPU;
    end else if (gnt[REQ_CPU]) begin
      ptr <= REQ_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and debugger onto a single-port sync RAM: grant at cycle N, mem at N+1, rvalid at N+3.
// Requesters hold until granted. MEM_ARBITER_LOCK_EN adds the debugger exclusive-lock FSM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_rw,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_data,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_rw,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_data,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [DATA_W-1:0] o_dbg_rdata,
  input  logic              i_dbg_lock,
  output logic              o_lock_ack,
  output logic              o_mem_en,
  output logic              o_mem_wea,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  logic [1:0]        req;
  logic [1:0]        mask;
  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  tag_t              new_tag;
  tag_t              t1;
  tag_t              t2;

`ifdef MEM_ARBITER_LOCK_EN
  state_t state;
  state_t state_nxt;
  logic   cpu_in_flight;

  assign cpu_in_flight = (t1.vld && t1.id == REQ_CPU) || (t2.vld && t2.id == REQ_CPU);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_RR;
    end else begin
      state <= state_nxt;
    end
  end

  // The CPU is blocked from the cycle lock rises until the cycle after it drops.
  always_comb begin
    state_nxt  = state;
    mask       = 2'b00;
    o_lock_ack = 1'b0;
    if (!i_dbg_lock) begin
      state_nxt = ST_RR;
    end else begin
      case (state)
        ST_RR:    state_nxt = ST_DRAIN;
        ST_DRAIN: if (!cpu_in_flight) state_nxt = ST_LOCKED;
        default:  state_nxt = ST_LOCKED;
      endcase
    end
    mask[REQ_CPU] = i_dbg_lock || (state != ST_RR);
    o_lock_ack    = (state == ST_LOCKED) && i_dbg_lock;
  end
`else
  logic unused_lock;
  assign unused_lock = i_dbg_lock;
  assign mask        = 2'b00;
  assign o_lock_ack  = 1'b0;
`endif

  always_comb begin
    req          = 2'b00;
    req[REQ_CPU] = i_cpu_req;
    req[REQ_DBG] = i_dbg_req;
  end

  mem_arbiter_rr u_rr (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .req   (req),
    .mask  (mask),
    .gnt   (pick)
  );

  assign gnt       = pick & {2{i_reset_n}};
  assign o_cpu_gnt = gnt[REQ_CPU];
  assign o_dbg_gnt = gnt[REQ_DBG];

  always_comb begin
    any_gnt         = |gnt;
    sel_rw          = gnt[REQ_DBG] ? i_dbg_rw   : i_cpu_rw;
    sel_addr        = gnt[REQ_DBG] ? i_dbg_addr : i_cpu_addr;
    sel_data        = gnt[REQ_DBG] ? i_dbg_data : i_cpu_data;
    new_tag.vld     = any_gnt;
    new_tag.id      = gnt[REQ_DBG] ? REQ_DBG : REQ_CPU;
    new_tag.is_read = any_gnt && sel_rw;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mem_en     <= 1'b0;
      o_mem_wea    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      t1           <= '0;
      t2           <= '0;
      o_cpu_rvalid <= 1'b0;
      o_dbg_rvalid <= 1'b0;
      o_cpu_rdata  <= '0;
      o_dbg_rdata  <= '0;
    end else begin
      o_mem_en     <= any_gnt;
      o_mem_wea    <= any_gnt && !sel_rw;
      o_mem_addr   <= any_gnt ? sel_addr : '0;
      o_mem_data   <= any_gnt ? sel_data : '0;
      t1           <= new_tag;
      t2           <= t1;
      o_cpu_rvalid <= t2.vld && t2.is_read && (t2.id == REQ_CPU);
      o_dbg_rvalid <= t2.vld && t2.is_read && (t2.id == REQ_DBG);
      // t2 lines up with the RAM output, so rdata is captured straight from it.
      if (t2.vld && t2.is_read && t2.id == REQ_CPU) o_cpu_rdata <= i_mem_data;
      if (t2.vld && t2.is_read && t2.id == REQ_DBG) o_dbg_rdata <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cpu_req, cpu_rw, dbg_req, dbg_rw, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_data, dbg_data;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, lock_ack;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_en, mem_wea;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, ram_q;
  logic [DW-1:0] ram [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wea) ram[mem_addr] <= mem_data;
      else         ram_q <= ram[mem_addr];
    end
  end

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_cpu_req(cpu_req), .i_cpu_rw(cpu_rw), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_rw(dbg_rw), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_data),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .i_dbg_lock(dbg_lock), .o_lock_ack(lock_ack),
    .o_mem_en(mem_en), .o_mem_wea(mem_wea), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .i_mem_data(ram_q)
  );

  task automatic idle();
    cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_data = '0;
    dbg_req = 1'b0; dbg_rw = 1'b0; dbg_addr = '0; dbg_data = '0;
    dbg_lock = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h1111; cpu_data = 8'h11;
    dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 16'h2222; dbg_data = 8'h22;
    dbg_lock = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt: got %b want 0", cpu_gnt); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_dbg_gnt: got %b want 0", dbg_gnt); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    checks++; if (mem_wea !== 1'b0) begin errors++; $display("FAIL rst_mem_wea: got %b want 0", mem_wea); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_data !== 8'h00) begin errors++; $display("FAIL rst_mem_data: got %h want 00", mem_data); end
    checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {cpu_rvalid, dbg_rvalid}); end
    checks++; if (lock_ack !== 1'b0) begin errors++; $display("FAIL rst_lock_ack: got %b want 0", lock_ack); end
    @(posedge clk); #1 idle(); reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    ram[16'h1234] = 8'h5A;
    @(posedge clk); #1 cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h1234;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL sr_cpu_gnt: got %b want 1", cpu_gnt); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL sr_dbg_gnt: got %b want 0", dbg_gnt); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_wea !== 1'b0) begin errors++; $display("FAIL sr_mem_en: got en=%b wea=%b want en=1 wea=0", mem_en, mem_wea); end
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL sr_mem_addr: got %h want 1234", mem_addr); end
    @(posedge clk); @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL sr_early_rvalid: got %b want 0", cpu_rvalid); end
    @(posedge clk); @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin errors++; $display("FAIL sr_return: got v=%b d=%h want v=1 d=5a", cpu_rvalid, cpu_rdata); end
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL sr_dbg_rvalid: got %b want 0", dbg_rvalid); end
    @(posedge clk); @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A) begin errors++; $display("FAIL sr_hold: got v=%b d=%h want v=0 d=5a", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_round_robin();
    int cpu_idx = 0;
    int dbg_idx = 0;
    logic exp_dbg;
    logic [7:0] exp_d;
    for (int i = 0; i < 3; i++) begin
      ram[16'h0100 + i] = 8'h10 + 8'(i);
      ram[16'h0300 + i] = 8'hC0 + 8'(i);
    end
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c < 6) begin
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0100 + 16'(cpu_idx);
        dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 16'h0300 + 16'(dbg_idx);
      end else begin
        idle();
      end
      @(negedge clk);
      if (c < 6) begin
        exp_dbg = (c % 2 == 0);
        checks++; if (dbg_gnt !== exp_dbg || cpu_gnt !== !exp_dbg) begin errors++; $display("FAIL rr_gnt[%0d]: got dbg=%b cpu=%b want dbg=%b", c, dbg_gnt, cpu_gnt, exp_dbg); end
        if (exp_dbg) dbg_idx++; else cpu_idx++;
      end
      if (c >= 3 && c < 9) begin
        if ((c - 3) % 2 == 0) begin
          exp_d = 8'hC0 + 8'((c - 3) / 2);
          checks++; if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== exp_d) begin errors++; $display("FAIL rr_ret[%0d]: got dv=%b cv=%b d=%h want dv=1 cv=0 d=%h", c, dbg_rvalid, cpu_rvalid, dbg_rdata, exp_d); end
        end else begin
          exp_d = 8'h10 + 8'((c - 3) / 2);
          checks++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== exp_d) begin errors++; $display("FAIL rr_ret[%0d]: got cv=%b dv=%b d=%h want cv=1 dv=0 d=%h", c, cpu_rvalid, dbg_rvalid, cpu_rdata, exp_d); end
        end
      end else if (c < 3) begin
        checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL rr_early[%0d]: got %b want 00", c, {cpu_rvalid, dbg_rvalid}); end
      end
    end
  endtask

  task automatic test_write_then_read();
    ram[16'h0200] = 8'h00;
    @(posedge clk); #1 idle(); dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 16'h0200; dbg_data = 8'hA7;
    @(negedge clk);
    checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt: got dbg=%b cpu=%b want dbg=1 cpu=0", dbg_gnt, cpu_gnt); end
    @(posedge clk); #1 idle(); cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0200;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_rd_gnt: got %b want 1", cpu_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_wea !== 1'b1 || mem_addr !== 16'h0200 || mem_data !== 8'hA7) begin errors++; $display("FAIL wr_mem: got en=%b wea=%b a=%h d=%h want 1 1 0200 a7", mem_en, mem_wea, mem_addr, mem_data); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_wea !== 1'b0) begin errors++; $display("FAIL wr_rd_mem: got en=%b wea=%b want en=1 wea=0", mem_en, mem_wea); end
    @(posedge clk); @(negedge clk);
    checks++; if (dbg_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got dv=%b cv=%b want 0 0", dbg_rvalid, cpu_rvalid); end
    @(posedge clk); @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA7) begin errors++; $display("FAIL wr_rd_ret: got v=%b d=%h want v=1 d=a7", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1 idle(); dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 16'h0301;
    @(negedge clk);
    checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", dbg_gnt); end
    @(posedge clk); #1 idle(); cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0100; reset_n = 1'b0;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL rm_gnt_rst: got cpu=%b dbg=%b want 0 0", cpu_gnt, dbg_gnt); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== 16'h0000) begin errors++; $display("FAIL rm_mem_rst: got en=%b a=%h want 0 0000", mem_en, mem_addr); end
    @(posedge clk); #1 idle(); reset_n = 1'b1;
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      checks++; if (dbg_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid[%0d]: got dv=%b cv=%b want 0 0", c, dbg_rvalid, cpu_rvalid); end
      @(posedge clk);
    end
  endtask

`ifdef MEM_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    @(posedge clk); #1 cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0100;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1 || lock_ack !== 1'b0) begin errors++; $display("FAIL lk_c0: got gnt=%b ack=%b want 1 0", cpu_gnt, lock_ack); end
    @(posedge clk); #1 cpu_addr = 16'h0101; dbg_lock = 1'b1;
    dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 16'h0400; dbg_data = 8'h33;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1 || lock_ack !== 1'b0) begin errors++; $display("FAIL lk_c1: got cpu=%b dbg=%b ack=%b want 0 1 0", cpu_gnt, dbg_gnt, lock_ack); end
    @(posedge clk); #1 dbg_req = 1'b0;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0 || lock_ack !== 1'b0) begin errors++; $display("FAIL lk_c2: got cpu=%b ack=%b want 0 0", cpu_gnt, lock_ack); end
    @(posedge clk); @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h10 || lock_ack !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL lk_c3: got v=%b d=%h ack=%b gnt=%b want 1 10 0 0", cpu_rvalid, cpu_rdata, lock_ack, cpu_gnt); end
    @(posedge clk); @(negedge clk);
    checks++; if (lock_ack !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL lk_c4: got ack=%b gnt=%b want 1 0", lock_ack, cpu_gnt); end
    @(posedge clk); #1 dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 16'h0300;
    @(negedge clk);
    checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || lock_ack !== 1'b1) begin errors++; $display("FAIL lk_c5: got dbg=%b cpu=%b ack=%b want 1 0 1", dbg_gnt, cpu_gnt, lock_ack); end
    @(posedge clk); #1 dbg_req = 1'b0; dbg_lock = 1'b0;
    @(negedge clk);
    checks++; if (lock_ack !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL lk_c6: got ack=%b gnt=%b want 0 0", lock_ack, cpu_gnt); end
    @(posedge clk); @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL lk_c7: got gnt=%b want 1", cpu_gnt); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 8'hC0) begin errors++; $display("FAIL lk_c8: got v=%b d=%h want 1 c0", dbg_rvalid, dbg_rdata); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h11) begin errors++; $display("FAIL lk_c10: got v=%b d=%h want 1 11", cpu_rvalid, cpu_rdata); end
  endtask
`else
  task automatic test_nolock();
    logic exp_dbg;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      dbg_lock = 1'b1;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0100;
      dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 16'h0300;
      @(negedge clk);
      exp_dbg = (c % 2 == 0);
      checks++; if (dbg_gnt !== exp_dbg || cpu_gnt !== !exp_dbg || lock_ack !== 1'b0) begin errors++; $display("FAIL nl_gnt[%0d]: got dbg=%b cpu=%b ack=%b want dbg=%b ack=0", c, dbg_gnt, cpu_gnt, lock_ack, exp_dbg); end
    end
    @(posedge clk); #1 idle();
    repeat (4) @(posedge clk);
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_reset_midflight();
`ifdef MEM_ARBITER_LOCK_EN
    test_lock();
`else
    test_nolock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of the shared memory port.
REQ-002 Parameter DATA_W, default 8, data width of the shared memory port.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_cpu_req, i_cpu_rw, i_cpu_addr, i_cpu_data  in  1/1/ADDR_W/DATA_W  CPU requester; rw 0=write, 1=read.
REQ-006 o_cpu_gnt  out  1  CPU request accepted this cycle.
REQ-007 o_cpu_rvalid, o_cpu_rdata  out  1/DATA_W  CPU read return.
REQ-008 i_dbg_req, i_dbg_rw, i_dbg_addr, i_dbg_data  in  1/1/ADDR_W/DATA_W  debugger requester; same encoding.
REQ-009 o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata  out  1/1/DATA_W  debugger grant and read return.
REQ-010 i_dbg_lock  in  1  debugger requests exclusive memory ownership.
REQ-011 o_lock_ack  out  1  exclusive ownership in force.
REQ-012 o_mem_en, o_mem_wea, o_mem_addr, o_mem_data  out  1/1/ADDR_W/DATA_W  to single-port synchronous RAM; wea=1 write.
REQ-013 i_mem_data  in  DATA_W  RAM read data, valid one cycle after o_mem_en.

Function
REQ-014 Requester holds req/rw/addr/data stable until gnt; gnt is combinational from current req and arbiter state, at most one gnt per cycle.
REQ-015 Both requesting, not locked: round-robin; 1-bit pointer favours the requester not granted last; pointer updates only on a grant.
REQ-016 Single requester: granted same cycle, pointer updated.
REQ-017 Accepted access in cycle N drives registered o_mem_* in cycle N+1; o_mem_en low when no grant in N.
REQ-018 Read accepted in N: o_<req>_rvalid high exactly cycle N+3, o_<req>_rdata = RAM data registered end of N+2; rdata holds until next rvalid for that requester.
REQ-019 Writes produce no rvalid; back-to-back accesses sustain one grant per cycle; returns in acceptance order.
REQ-020 2-stage in-flight tag pipeline carries {valid, requester id, is_read}.
REQ-021 FSM states RR, DRAIN, LOCKED; RR->DRAIN when i_dbg_lock rises; DRAIN: CPU never granted, debugger granted; DRAIN->LOCKED when no CPU tag in flight (including any CPU grant in the DRAIN entry cycle).
REQ-022 LOCKED: o_lock_ack=1, only debugger granted; i_dbg_lock low in any state -> RR next cycle, o_lock_ack low the same cycle lock drops (combinational clear).
REQ-023 i_dbg_lock high and i_dbg_req in same cycle as transition: debugger grant allowed, CPU grant blocked from that cycle.

Reset
REQ-024 Reset asserted: o_mem_en, o_mem_wea, all gnt, rvalid, o_lock_ack = 0; addr/data outputs 0; FSM = RR; pointer favours debugger.
REQ-025 Reset mid-operation discards in-flight tags; no rvalid is issued for accesses accepted before reset.

Configuration
REQ-026 Macro MEM_ARBITER_LOCK_EN defined: REQ-021..023 implemented.
REQ-027 Macro absent: i_dbg_lock ignored, o_lock_ack tied 0, FSM omitted, arbiter always RR.

Structure
REQ-028 Package mem_arbiter_pkg holds FSM state enum, requester id constants (REQ_CPU=0, REQ_DBG=1), read latency constant (3), tag struct.
REQ-029 Sub-module mem_arbiter_rr: two-requester round-robin picker with mask input for lock blocking.

Verification
REQ-030 CPU read 0x1234 alone, RAM holds 0x5A -> gnt cycle N, o_mem_en/addr 0x1234 N+1, o_cpu_rvalid N+3 with 0x5A.
REQ-031 Both requesting reads continuously for 6 cycles -> grants alternate DBG,CPU,DBG,... from reset; each returns own data, in order.
REQ-032 Debugger write 0x0200<-0xA7 then CPU read 0x0200 next cycle -> CPU rvalid returns 0xA7.
REQ-033 CPU read in flight, i_dbg_lock raised -> DRAIN, o_lock_ack high only after CPU tag retires; CPU req held thereafter gets no gnt; lock dropped -> CPU granted next cycle.
REQ-034 Reset pulsed one cycle after debugger read accepted -> no o_dbg_rvalid; all outputs 0 during reset.
REQ-035 Build without MEM_ARBITER_LOCK_EN, i_dbg_lock=1 -> CPU still granted round-robin, o_lock_ack stays 0.
